ser_arbiter: RTL and testbench

Round-robin arbiter that shares one 64→16 serializer between N word-wide requesters. Sits directly in front of the serializer: each requester offers 64-bit words with a valid/stop handshake; the arbiter grants one owner at a time, registers the owner's word and presents it on the serializer's wdata/valid_in, obeying the serializer's stop_out.

---
 rtl/ser_arb_pkg.sv | 32 +++
 rtl/ser_arb_if.sv | 30 +++
 rtl/ser_arbiter_rr_pick.sv | 35 +++
 rtl/ser_arbiter.sv | 141 ++++++++++++++
 tb/tb_ser_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ser_arb_pkg.sv
// Shared types and constants for the serializer front-end arbiter.
package ser_arb_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 64;

  typedef enum logic {
    FREE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Ceiling log2, used to size the round-robin pointer.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Pointer width, never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int DEF_PTR_W = ptr_w(DEF_N);

endpackage

// File: rtl/ser_arb_if.sv
// Requester-side and serializer-side handshake bundle of the arbiter.
interface ser_arb_if
  import ser_arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
);

  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_last;
  logic [N-1:0]       req_stop;
  logic [WIDTH-1:0]   ser_wdata;
  logic               ser_valid;
  logic               ser_stop;
  logic [N-1:0]       grant;

  // Environment side: requesters plus the serializer's stop_out.
  modport master (
    output req_data, req_valid, req_last, ser_stop,
    input  req_stop, ser_wdata, ser_valid, grant
  );

  // Arbiter side.
  modport slave (
    input  req_data, req_valid, req_last, ser_stop,
    output req_stop, ser_wdata, ser_valid, grant
  );

endinterface

// File: rtl/ser_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick
  import ser_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int PW = DEF_PTR_W
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic found;

  // Scan ptr..N-1 first, then 0..ptr-1, so the search wraps without modulo math.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PW'(i) >= ptr)) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PW'(i) < ptr)) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/ser_arbiter.sv
// Round-robin arbiter sharing one 64->16 serializer between N requesters.
// Optional build macro SER_ARB_BURST_EN: the owner keeps the grant across
// transfers until a word with req_last; without it every transfer frees the bus.
module ser_arbiter
  import ser_arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic     clk,
  input logic     res,
  ser_arb_if.slave bus
);

  localparam int PW = ptr_w(N);

  state_t           state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    pick_idx, owner_inc;
  logic [N-1:0]     grant_q, grant_d;
  logic [N-1:0]     pick, req_stop_c;
  logic             pick_vld, owner_valid, xfer, drain;
  logic [WIDTH-1:0] owner_word, wdata_p1;
  logic             vld_p1;
`ifdef SER_ARB_BURST_EN
  logic             owner_last;
`else
  logic             unused_last;
  assign unused_last = ^bus.req_last;
`endif

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  // Decode the pick to an index and route the current owner's lane.
  always_comb begin
    pick_idx    = '0;
    owner_valid = 1'b0;
    owner_word  = '0;
`ifdef SER_ARB_BURST_EN
    owner_last  = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_idx = PW'(i);
      if (owner_q == PW'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_word  = bus.req_data[i*WIDTH +: WIDTH];
`ifdef SER_ARB_BURST_EN
        owner_last  = bus.req_last[i];
`endif
      end
    end
  end

  assign owner_inc = (owner_q == PW'(N-1)) ? '0 : owner_q + 1'b1;
  // The owner is accepted whenever the buffer is empty or draining this cycle.
  assign xfer  = (state_q == OWNED) & owner_valid & ~(vld_p1 & bus.ser_stop);
  assign drain = vld_p1 & ~bus.ser_stop;

  // State register: FSM state, owner, round-robin pointer and registered grant.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= FREE;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic: arbitrate in FREE, release on transfer or idle owner.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    case (state_q)
      FREE: begin
        if (pick_vld) begin
          state_d = OWNED;
          owner_d = pick_idx;
        end
      end
      OWNED: begin
`ifdef SER_ARB_BURST_EN
        if (xfer && owner_last) begin
          state_d = FREE;
          ptr_d   = owner_inc;
        end
`else
        if (xfer) begin
          state_d = FREE;
          ptr_d   = owner_inc;
        end else if (!owner_valid) begin
          state_d = FREE;
        end
`endif
      end
      default: state_d = FREE;
    endcase
    for (int i = 0; i < N; i++) begin
      if ((state_d == OWNED) && (owner_d == PW'(i))) grant_d[i] = 1'b1;
    end
  end

  // Output logic: stall everyone except an owner that can be accepted.
  always_comb begin
    req_stop_c = '1;
    for (int i = 0; i < N; i++) begin
      if ((state_q == OWNED) && (owner_q == PW'(i))) req_stop_c[i] = vld_p1 & bus.ser_stop;
    end
  end

  // Single-word output buffer: load on owner transfer, empty on a plain drain.
  always_ff @(posedge clk) begin
    if (res) begin
      wdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (xfer) begin
      wdata_p1 <= owner_word;
      vld_p1   <= 1'b1;
    end else if (drain) begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.req_stop  = req_stop_c;
  assign bus.grant     = grant_q;
  assign bus.ser_wdata = wdata_p1;
  assign bus.ser_valid = vld_p1;

endmodule

// File: tb/tb_ser_arbiter.sv
// Scoreboard bench for ser_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_ser_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic clk;
  logic res;

  ser_arb_if #(.N(N), .WIDTH(W)) bus ();

  ser_arbiter #(.N(N), .WIDTH(W)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus applied at the next falling edge.
  logic         res_v;
  logic [N-1:0] rv;
  logic [N-1:0] rl;
  logic [W-1:0] rd [N];
  logic         sstop;

  // Reference model state.
  int           m_owner;
  int           m_ptr;
  bit           m_full;
  logic [W-1:0] m_wdata;
  int           m_xfer;
  bit           m_known;
  logic [W-1:0] exp_q[$];

  // Snapshots of the DUT taken mid-cycle.
  logic [N-1:0] s_grant;
  logic [N-1:0] s_stop;
  logic         s_valid;
  logic [W-1:0] s_wdata;

  int n_pass;
  int n_total;
  logic [W-1:0] mon_w;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endfunction

  // One clock: drive at negedge, compare outputs, advance the model at posedge.
  task automatic step();
    logic [N-1:0] ms;
    logic [N-1:0] eg;
    bit drain;
    int nxt;
    int j;
    @(negedge clk);
    res = res_v;
    bus.req_valid = rv;
    bus.req_last  = rl;
    bus.ser_stop  = sstop;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = rd[i];
    #1;
    ms = '1;
    eg = '0;
    if (m_owner >= 0) begin
      ms[m_owner] = m_full & sstop;
      eg[m_owner] = 1'b1;
    end
    s_grant = bus.grant;
    s_stop  = bus.req_stop;
    s_valid = bus.ser_valid;
    s_wdata = bus.ser_wdata;
    if (m_known) begin
      chk("grant", 64'(s_grant), 64'(eg));
      chk("req_stop", 64'(s_stop), 64'(ms));
      chk("ser_valid", 64'(s_valid), 64'(m_full));
      chk("ser_wdata", s_wdata, m_wdata);
    end
    @(posedge clk);
    m_xfer = -1;
    if (res_v) begin
      m_known = 1'b1;
      m_owner = -1;
      m_ptr   = 0;
      m_full  = 1'b0;
      m_wdata = '0;
      exp_q.delete();
    end else begin
      drain = m_full && !sstop;
      if (m_owner < 0) begin
        nxt = -1;
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (nxt < 0 && rv[j]) nxt = j;
        end
        m_owner = nxt;
      end else if (rv[m_owner] && !ms[m_owner]) begin
        m_xfer  = m_owner;
        m_wdata = rd[m_owner];
        exp_q.push_back(rd[m_owner]);
`ifdef SER_ARB_BURST_EN
        if (rl[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
`else
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
`endif
      end else if (!rv[m_owner]) begin
`ifndef SER_ARB_BURST_EN
        m_owner = -1;
`endif
      end
      if (m_xfer >= 0) m_full = 1'b1;
      else if (drain)  m_full = 1'b0;
    end
  endtask

  task automatic do_reset();
    res_v = 1'b1;
    rv    = '0;
    rl    = '1;
    sstop = 1'b0;
    step();
    res_v = 1'b0;
  endtask

  // Monitor: every serializer accept must match the oldest expected word.
  always @(negedge clk) begin
    #2;
    if (m_known && bus.ser_valid === 1'b1 && bus.ser_stop === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("sb_nonempty", 64'd0, 64'd1);
      end else begin
        mon_w = exp_q.pop_front();
        chk("sb_word", bus.ser_wdata, mon_w);
      end
    end
  end

  logic [N-1:0] gseq[$];
  int           xcnt[N];

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_known = 1'b0;
    m_owner = -1;
    m_ptr   = 0;
    m_full  = 1'b0;
    m_wdata = '0;
    m_xfer  = -1;
    res     = 1'b1;
    res_v   = 1'b1;
    rv      = '0;
    rl      = '1;
    sstop   = 1'b0;
    for (int i = 0; i < N; i++) rd[i] = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.ser_stop  = 1'b0;

    // Reset state.
    do_reset();
    step();
    chk("rst_grant", 64'(s_grant), 64'h0);
    chk("rst_stop", 64'(s_stop), 64'hf);
    chk("rst_valid", 64'(s_valid), 64'h0);
    chk("rst_wdata", s_wdata, 64'h0);

    // Single requester.
    do_reset();
    rv = 4'b0001;
    rd[0] = 64'h0123_4567_89AB_CDEF;
    step();
    step();
    chk("a_grant", 64'(s_grant), 64'h1);
    chk("a_stop", 64'(s_stop), 64'he);
    rv = '0;
    step();
    chk("a_wdata", s_wdata, 64'h0123_4567_89AB_CDEF);
    chk("a_valid", 64'(s_valid), 64'h1);
    chk("a_free", 64'(s_grant), 64'h0);

    // All four requesting continuously.
    do_reset();
    rv = 4'b1111;
    for (int i = 0; i < N; i++) begin
      rd[i] = {32'hA0A0_0000 + 32'(i), 32'h0};
      xcnt[i] = 0;
    end
    gseq.delete();
    for (int c = 0; c < 16; c++) begin
      step();
      if (s_grant != '0) gseq.push_back(s_grant);
      if (m_xfer >= 0) begin
        xcnt[m_xfer]++;
        rd[m_xfer] = rd[m_xfer] + 64'd1;
      end
    end
    chk("rr_count", 64'(gseq.size()), 64'd8);
    for (int k = 0; k < 8 && k < gseq.size(); k++)
      chk("rr_order", 64'(gseq[k]), 64'(4'b0001 << (k % 4)));
    for (int i = 0; i < N; i++) chk("rr_served", 64'(xcnt[i]), 64'd2);

    // Backpressure with a full buffer.
    do_reset();
    rv = 4'b0001;
    rd[0] = 64'h1111_0000_0000_0000;
    step();
    step();
    rv = 4'b0010;
    rd[1] = 64'h2222_0000_0000_0001;
    sstop = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_stop", 64'(s_stop[1]), 64'h1);
      chk("bp_hold", s_wdata, 64'h1111_0000_0000_0000);
    end
    sstop = 1'b0;
    step();
    chk("bp_accept", 64'(s_stop[1]), 64'h0);
    rv = '0;
    step();
    chk("bp_load_valid", 64'(s_valid), 64'h1);
    chk("bp_load_word", s_wdata, 64'h2222_0000_0000_0001);

`ifndef SER_ARB_BURST_EN
    // Owner drops valid while stalled.
    do_reset();
    rv = 4'b0010;
    rd[1] = 64'h3333;
    step();
    step();
    rv = 4'b0100;
    rd[2] = 64'h4444;
    sstop = 1'b1;
    step();
    rv = '0;
    step();
    chk("drop_grant", 64'(s_grant), 64'h4);
    rv = 4'b1000;
    rd[3] = 64'h5555;
    step();
    chk("drop_free", 64'(s_grant), 64'h0);
    step();
    chk("drop_next", 64'(s_grant), 64'h8);
    sstop = 1'b0;
    rv = '0;
    step();
    step();
`else
    // Burst from requester 1 while requester 3 waits.
    do_reset();
    rv = 4'b1010;
    rl = 4'b1000;
    rd[1] = 64'h1A;
    rd[3] = 64'h3A;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2) chk("burst_grant1", 64'(s_grant), 64'h2);
      if (c == 3) chk("burst_w1a", s_wdata, 64'h1A);
      if (c == 4) chk("burst_w1b", s_wdata, 64'h1B);
      if (c == 5) chk("burst_w1c", s_wdata, 64'h1C);
      if (c >= 3 && c <= 5) chk("burst_valid", 64'(s_valid), 64'h1);
      if (c == 6) chk("burst_grant3", 64'(s_grant), 64'h8);
      if (m_xfer == 1) begin
        if (rd[1] == 64'h1A) rd[1] = 64'h1B;
        else if (rd[1] == 64'h1B) begin rd[1] = 64'h1C; rl[1] = 1'b1; end
        else rv[1] = 1'b0;
      end
      if (m_xfer == 3) rv[3] = 1'b0;
    end
    step();
    step();
`endif

    // Reset while owned with a full buffer.
    do_reset();
    rv = 4'b0001;
    rd[0] = 64'hDEAD_BEEF;
    step();
    step();
    rv = 4'b0010;
    sstop = 1'b1;
    step();
    step();
    res_v = 1'b1;
    step();
    res_v = 1'b0;
    rv = '0;
    sstop = 1'b0;
    step();
    chk("mid_rst_valid", 64'(s_valid), 64'h0);
    chk("mid_rst_grant", 64'(s_grant), 64'h0);
    chk("mid_rst_stop", 64'(s_stop), 64'hf);
    chk("mid_rst_wdata", s_wdata, 64'h0);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      step();
      if (m_xfer >= 0) rv[m_xfer] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(2) == 0) begin
          rv[i] = 1'b1;
          rd[i] = {$urandom, $urandom};
          rl[i] = ($urandom_range(2) == 0);
        end
      end
      sstop = ($urandom_range(9) < 6);
    end

    // Drain and confirm every expected word was delivered.
    rv = '0;
    sstop = 1'b0;
    for (int c = 0; c < 6; c++) step();
    chk("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
